// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
//   Shared definitions for the instruction/data memory arbiter:
//   the arbiter FSM state type and the default address width and
//   starvation limit used as parameter defaults.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_MAX_WAIT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between an instruction-fetch port and a
//   data port. Every access is two cycles: an issue cycle (mem_en high,
//   taken from IDLE) followed by an ack cycle (BUSY_I / BUSY_D) in which the
//   memory read data is returned to the granted requester.
//   Data has fixed priority over instruction fetch.
//
//   Build option: ARB_STARVE_GUARD_EN
//     defined   - a saturating wait counter counts IDLE cycles in which a
//                 pending fetch lost to data; at MAX_WAIT the fetch is
//                 forced through ahead of data.
//     undefined - strict data priority, no counter.
//
//   Ports
//     clk, rst                  clock, asynchronous active-high reset
//     i_req/i_addr              fetch request and byte address
//     i_ack/i_rdata             fetch completion pulse and data
//     d_req/d_addr/d_we/d_wdata data request, byte address, lane enables, data
//     d_ack/d_rdata             data completion pulse and read data
//     mem_en/mem_addr/mem_we/mem_wdata/mem_rdata  memory side
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   ST_IDLE   | arbitrate; issue the winning access this cycle
//   ST_BUSY_I | memory data valid; ack the fetch
//   ST_BUSY_D | memory data valid; ack the data access
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  arb_state_t state, state_nxt;
  logic       idle_issue;
  logic       grant_i;
  logic       grant_d;
  logic       force_i;

  // Outputs are combinational from state; gating with rst keeps the
  // memory strobe quiet while reset is held even if requests are high.
  assign idle_issue = (state == ST_IDLE) && !rst;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;

  assign force_i = (wait_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (grant_i) begin
      wait_cnt <= '0;
    end else if (grant_d && i_req && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign force_i = 1'b0;
`endif

  // Forcing only overrides data when a fetch is actually pending.
  assign grant_d = idle_issue && d_req && !(force_i && i_req);
  assign grant_i = idle_issue && i_req && !grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_d) begin
          state_nxt = ST_BUSY_D;
        end else if (grant_i) begin
          state_nxt = ST_BUSY_I;
        end
      end
      ST_BUSY_I: state_nxt = ST_IDLE;
      ST_BUSY_D: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_we    = 4'b0000;
    mem_wdata = 32'h0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    i_rdata   = 32'h0;
    d_rdata   = 32'h0;

    if (grant_d) begin
      mem_en    = 1'b1;
      mem_addr  = d_addr & WORD_MASK;
      mem_we    = d_we;
      mem_wdata = d_wdata;
    end else if (grant_i) begin
      mem_en    = 1'b1;
      mem_addr  = i_addr & WORD_MASK;
    end

    if (!rst) begin
      if (state == ST_BUSY_I) begin
        i_ack   = 1'b1;
        i_rdata = mem_rdata;
      end else if (state == ST_BUSY_D) begin
        d_ack   = 1'b1;
        d_rdata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Inputs change 1 ns after the rising
//   edge; outputs are compared 1 ns later, well away from the next edge.
//   Expectations follow ARB_STARVE_GUARD_EN when the bench is built with it.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [3:0]        d_we;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int checks;
  int failures;

  mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_we      (d_we),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue-cycle checks: strobe, aligned address, enables, write data.
  task automatic chk_issue(input string tag, input logic [31:0] addr,
                           input logic [3:0] we, input logic [31:0] wdata);
    chk({tag, "_en"},    32'(mem_en), 32'd1);
    chk({tag, "_addr"},  mem_addr, addr);
    chk({tag, "_we"},    32'(mem_we), 32'(we));
    chk({tag, "_wdata"}, mem_wdata, wdata);
    chk({tag, "_acks"},  32'({i_ack, d_ack}), 32'd0);
  endtask

  // Ack-cycle checks: exactly one ack, data routing, memory side idle.
  task automatic chk_ack(input string tag, input logic is_d, input logic [31:0] rd);
    chk({tag, "_iack"},  32'(i_ack), 32'(!is_d));
    chk({tag, "_dack"},  32'(d_ack), 32'(is_d));
    chk({tag, "_irdata"}, i_rdata, is_d ? 32'h0 : rd);
    chk({tag, "_drdata"}, d_rdata, is_d ? rd : 32'h0);
    chk({tag, "_memen"}, 32'(mem_en), 32'd0);
    chk({tag, "_memaddr"}, mem_addr, 32'h0);
    chk({tag, "_memwe"}, 32'(mem_we), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_addr;
    int          i_grants;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_addr    = '0;
    d_we      = 4'b0;
    d_wdata   = 32'h0;
    mem_rdata = 32'h0;

    // Reset: quiet outputs, even with a request pending.
    #2;
    chk("rst_memen", 32'(mem_en), 32'd0);
    chk("rst_acks",  32'({i_ack, d_ack}), 32'd0);
    d_req  = 1'b1;
    d_addr = 32'h0000_0010;
    #1;
    chk("rst_memen_req", 32'(mem_en), 32'd0);
    chk("rst_memwe",     32'(mem_we), 32'd0);
    tick();
    rst   = 1'b0;
    d_req = 1'b0;
    #1;
    chk("post_rst_memen", 32'(mem_en), 32'd0);

    // Fetch only, address 0x104.
    tick();
    i_req  = 1'b1;
    i_addr = 32'h0000_0104;
    #1;
    chk_issue("ifetch", 32'h104, 4'b0000, 32'h0);
    tick();
    mem_rdata = 32'h1122_3344;
    #1;
    chk_ack("ifetch_ack", 1'b0, 32'h1122_3344);
    i_req = 1'b0;

    // Misaligned byte write to lane 3.
    tick();
    d_req   = 1'b1;
    d_addr  = 32'h0000_0203;
    d_we    = 4'b1000;
    d_wdata = 32'hAA00_0000;
    #1;
    chk_issue("dwrite", 32'h200, 4'b1000, 32'hAA00_0000);
    tick();
    mem_rdata = 32'h5555_0000;
    #1;
    chk_ack("dwrite_ack", 1'b1, 32'h5555_0000);
    d_req = 1'b0;
    d_we  = 4'b0000;

    // Simultaneous requests: D first, then I, four cycles total.
    tick();
    i_req   = 1'b1;
    i_addr  = 32'h0000_0300;
    d_req   = 1'b1;
    d_addr  = 32'h0000_0406;
    d_wdata = 32'h0;
    #1;
    chk_issue("both_d", 32'h404, 4'b0000, 32'h0);
    tick();
    mem_rdata = 32'hDDDD_0404;
    #1;
    chk_ack("both_d_ack", 1'b1, 32'hDDDD_0404);
    d_req = 1'b0;
    tick();
    #1;
    chk_issue("both_i", 32'h300, 4'b0000, 32'h0);
    tick();
    mem_rdata = 32'h1111_0300;
    #1;
    chk_ack("both_i_ack", 1'b0, 32'h1111_0300);
    i_req = 1'b0;

    // Continuous D traffic with a pending fetch.
    tick();
    i_req    = 1'b1;
    i_addr   = 32'h0000_0600;
    d_req    = 1'b1;
    d_addr   = 32'h0000_0500;
    i_grants = 0;
    for (int g = 0; g < 6; g++) begin
      #1;
`ifdef ARB_STARVE_GUARD_EN
      exp_addr = (g == 4) ? 32'h600 : 32'h500;
`else
      exp_addr = 32'h500;
`endif
      chk($sformatf("starve_issue%0d", g), mem_addr, exp_addr);
      if (mem_addr == 32'h600) i_grants++;
      tick();
      mem_rdata = 32'h0BAD_0000 + 32'(g);
      #1;
      chk_ack($sformatf("starve_ack%0d", g), exp_addr == 32'h500, 32'h0BAD_0000 + 32'(g));
      if (g == 5) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end else if (exp_addr == 32'h600) begin
        i_req = 1'b0;
      end
      tick();
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_igrants", 32'(i_grants), 32'd1);
`else
    chk("starve_igrants", 32'(i_grants), 32'd0);
`endif

    // Reset during the ack cycle of a data access.
    d_req  = 1'b1;
    d_addr = 32'h0000_0701;
    d_we   = 4'b0000;
    #1;
    chk_issue("rstmid", 32'h700, 4'b0000, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    chk("rstmid_dack",  32'(d_ack), 32'd0);
    chk("rstmid_memen", 32'(mem_en), 32'd0);
    tick();
    chk("rstmid_dack2", 32'(d_ack), 32'd0);
    rst = 1'b0;
    #1;
    chk_issue("rstmid_reissue", 32'h700, 4'b0000, 32'h0);
    tick();
    mem_rdata = 32'h7777_0700;
    #1;
    chk_ack("rstmid_ack", 1'b1, 32'h7777_0700);
    d_req = 1'b0;
    tick();
    #1;
    chk("final_idle_memen", 32'(mem_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
